// File: rtl/ime_search_ctrl_if.sv
// Handshake and result bus between the MB encoder / IME SAD datapath and ime_search_ctrl.
// The slave modport is the controller's view; master is the encoder/datapath side.
interface ime_search_ctrl_if #(
  parameter int MV_W  = 7,
  parameter int SAD_W = 16
);
  logic                   start_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   cand_v_o;
  logic                   cand_rdy_i;
  logic [2*MV_W-1:0]      cand_mv_o;
  logic                   sad_v_i;
  logic [4*SAD_W-1:0]     sad8x8_i;
  logic [2*SAD_W-1:0]     sad8x16_i;
  logic [2*SAD_W-1:0]     sad16x8_i;
  logic [SAD_W-1:0]       sad16x16_i;
  logic [9*2*MV_W-1:0]    best_mv_o;
  logic [9*SAD_W-1:0]     best_sad_o;

  modport slave (
    input  start_i, cand_rdy_i, sad_v_i, sad8x8_i, sad8x16_i, sad16x8_i, sad16x16_i,
    output busy_o, done_o, cand_v_o, cand_mv_o, best_mv_o, best_sad_o
  );

  modport master (
    output start_i, cand_rdy_i, sad_v_i, sad8x8_i, sad8x16_i, sad16x8_i, sad16x16_i,
    input  busy_o, done_o, cand_v_o, cand_mv_o, best_mv_o, best_sad_o
  );
endinterface

// File: rtl/ime_search_ctrl.sv
// Integer-ME full-search sequencer: issues candidate MVs in raster order and tracks the
// minimum-SAD MV for each of the 9 partitions of a 16x16 macroblock.
module ime_search_ctrl #(
  parameter int SR    = 16,
  parameter int MV_W  = 7,
  parameter int SAD_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  ime_search_ctrl_if.slave    bus
);

  localparam int SIDE  = 2 * SR;
  localparam int AXW   = $clog2(SIDE);
  localparam int CNT_W = 2 * AXW;
  localparam int NCAND = SIDE * SIDE;
  localparam int NPART = 9;

  localparam logic [CNT_W:0]  LAST_IDX = (CNT_W+1)'(NCAND - 1);
  localparam logic [CNT_W:0]  CNT_ONE  = (CNT_W+1)'(1);
  localparam logic [MV_W-1:0] MV_MIN   = MV_W'(-SR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Counter index splits as {y_idx, x_idx}; subtracting SR maps each index to a signed MV.
  function automatic logic [2*MV_W-1:0] idx_to_mv(input logic [CNT_W-1:0] idx);
    logic [MV_W-1:0] mv_x;
    logic [MV_W-1:0] mv_y;
    mv_x = MV_W'(idx[AXW-1:0]) - MV_W'(SR);
    mv_y = MV_W'(idx[CNT_W-1:AXW]) - MV_W'(SR);
    return {mv_y, mv_x};
  endfunction

  state_e               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cand_v_q;
  logic [2*MV_W-1:0]    cand_mv_q;
  logic [CNT_W:0]       issue_cnt_q;
  logic [CNT_W:0]       ret_cnt_q;
  logic [SAD_W-1:0]     best_sad_q [NPART];
  logic [2*MV_W-1:0]    best_mv_q  [NPART];

  logic [CNT_W:0]       issue_cnt_d;
  logic [CNT_W:0]       ret_cnt_d;
  logic                 issue_hs_s;
  logic                 ret_accept_s;
  logic [2*MV_W-1:0]    ret_mv_s;
  logic [SAD_W-1:0]     sad_in_s   [NPART];
  logic                 better_s   [NPART];

  assign issue_cnt_d  = issue_cnt_q + CNT_ONE;
  assign ret_cnt_d    = ret_cnt_q + CNT_ONE;
  assign issue_hs_s   = cand_v_q & bus.cand_rdy_i;
  assign ret_accept_s = bus.sad_v_i & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign ret_mv_s     = idx_to_mv(ret_cnt_q[CNT_W-1:0]);

  // Unpack the SAD tree outputs into the result ordering: 16x16, 16x8 x2, 8x16 x2, 8x8 x4.
  always_comb begin
    sad_in_s[0] = bus.sad16x16_i;
    sad_in_s[1] = bus.sad16x8_i[SAD_W-1:0];
    sad_in_s[2] = bus.sad16x8_i[2*SAD_W-1:SAD_W];
    sad_in_s[3] = bus.sad8x16_i[SAD_W-1:0];
    sad_in_s[4] = bus.sad8x16_i[2*SAD_W-1:SAD_W];
    for (int k = 0; k < 4; k++) begin
      sad_in_s[5+k] = bus.sad8x8_i[k*SAD_W +: SAD_W];
    end
  end

  // Strict less-than so that ties keep the earlier raster candidate.
  always_comb begin
    for (int p = 0; p < NPART; p++) begin
      better_s[p] = (sad_in_s[p] < best_sad_q[p]);
    end
  end

  // Search FSM, issue/return counters and per-partition best tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cand_v_q    <= 1'b0;
      cand_mv_q   <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      for (int p = 0; p < NPART; p++) begin
        best_sad_q[p] <= '0;
        best_mv_q[p]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            cand_v_q    <= 1'b1;
            cand_mv_q   <= {MV_MIN, MV_MIN};
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            for (int p = 0; p < NPART; p++) begin
              best_sad_q[p] <= '1;
              best_mv_q[p]  <= '0;
            end
          end
        end
        S_RUN: begin
          if (issue_hs_s) begin
            issue_cnt_q <= issue_cnt_d;
            if (issue_cnt_q == LAST_IDX) begin
              cand_v_q <= 1'b0;
              state_q  <= S_DRAIN;
            end else begin
              cand_mv_q <= idx_to_mv(issue_cnt_d[CNT_W-1:0]);
            end
          end
        end
        S_DRAIN: begin
          if (bus.sad_v_i && (ret_cnt_q == LAST_IDX)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          cand_v_q <= 1'b0;
        end
      endcase

      // Results are only meaningful while a search is in flight.
      if (ret_accept_s) begin
        ret_cnt_q <= ret_cnt_d;
        for (int p = 0; p < NPART; p++) begin
          if (better_s[p]) begin
            best_sad_q[p] <= sad_in_s[p];
            best_mv_q[p]  <= ret_mv_s;
          end
        end
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.cand_v_o  = cand_v_q;
  assign bus.cand_mv_o = cand_mv_q;

  for (genvar gp = 0; gp < NPART; gp++) begin : g_pack
    assign bus.best_mv_o[gp*2*MV_W +: 2*MV_W] = best_mv_q[gp];
    assign bus.best_sad_o[gp*SAD_W +: SAD_W]  = best_sad_q[gp];
  end

endmodule

// File: tb/tb_ime_search_ctrl.sv
// Directed bench for ime_search_ctrl at SR=2: a datapath model returns SAD sets in issue
// order while the main sequence checks issue order, completion timing and best-MV results.
module tb_ime_search_ctrl;
  localparam int SR = 2, MV_W = 7, SAD_W = 16, NC = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ime_search_ctrl_if #(.MV_W(MV_W), .SAD_W(SAD_W)) bus ();
  ime_search_ctrl #(.SR(SR), .MV_W(MV_W), .SAD_W(SAD_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;
  int mode = 1;
  bit rand_rdy = 1'b0;
  bit rand_lat = 1'b0;
  bit inject = 1'b0;
  int cyc = 0;
  int exp_iss = 0;
  int ret_idx = 0;
  int last_sad_cyc = -100;
  int last_due = 0;
  int due_q[$];
  bit prev_stall = 1'b0;
  bit prev_busy = 1'b0;
  logic [2*MV_W-1:0] prev_mv = '0;

  function automatic logic [13:0] mvp(input int y, input int x);
    logic [6:0] yy, xx;
    yy = 7'(y);
    xx = 7'(x);
    return {yy, xx};
  endfunction

  function automatic logic [13:0] idx_mv(input int idx);
    return mvp(idx / 4 - 2, idx % 4 - 2);
  endfunction

  // Candidate index where partition p has its planted minimum in mode 3.
  function automatic int plant(input int p);
    case (p)
      0: return 13;  1: return 2;  2: return 7;
      3: return 0;   4: return 15; 5: return 9;
      6: return 4;   7: return 11; 8: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] sad_for(input int m, input int idx, input int p);
    case (m)
      1: return 16'd100;
      2: return (p == 0 && idx == 11) ? 16'd50 : 16'd200;
      3: return (idx == plant(p)) ? 16'(10 + p) : 16'd500;
      default: return 16'd999;
    endcase
  endfunction

  // Datapath model: owns cand_rdy_i / sad_v_i, checks issue order and stall stability.
  always @(negedge clk) begin : resp
    int lat;
    int d;
    cyc = cyc + 1;
    if (!rstn) begin
      due_q.delete();
      exp_iss = 0;
      ret_idx = 0;
      prev_stall = 1'b0;
      prev_busy = 1'b0;
      bus.cand_rdy_i = 1'b0;
      bus.sad_v_i = 1'b0;
    end else begin
      if (bus.busy_o && !prev_busy) begin
        exp_iss = 0;
        ret_idx = 0;
        due_q.delete();
      end
      prev_busy = bus.busy_o;
      if (prev_stall) begin
        checks++;
        assert (bus.cand_v_o === 1'b1 && bus.cand_mv_o === prev_mv) else begin
          errors++;
          $error("FAIL stall_hold: observed v=%b mv=%h expected v=1 mv=%h", bus.cand_v_o, bus.cand_mv_o, prev_mv);
        end
      end
      bus.cand_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.cand_v_o && bus.cand_rdy_i) begin
        checks++;
        assert (exp_iss < NC && bus.cand_mv_o === idx_mv(exp_iss)) else begin
          errors++;
          $error("FAIL issue_order[%0d]: observed %h expected %h", exp_iss, bus.cand_mv_o, idx_mv(exp_iss));
        end
        lat = rand_lat ? int'($urandom_range(1, 6)) : 3;
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        due_q.push_back(d);
        exp_iss++;
      end
      prev_stall = bus.cand_v_o && !bus.cand_rdy_i;
      prev_mv = bus.cand_mv_o;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        bus.sad_v_i = 1'b1;
        bus.sad16x16_i = sad_for(mode, ret_idx, 0);
        bus.sad16x8_i = {sad_for(mode, ret_idx, 2), sad_for(mode, ret_idx, 1)};
        bus.sad8x16_i = {sad_for(mode, ret_idx, 4), sad_for(mode, ret_idx, 3)};
        bus.sad8x8_i = {sad_for(mode, ret_idx, 8), sad_for(mode, ret_idx, 7),
                        sad_for(mode, ret_idx, 6), sad_for(mode, ret_idx, 5)};
        ret_idx++;
        last_sad_cyc = cyc;
      end else if (inject) begin
        bus.sad_v_i = 1'b1;
        bus.sad16x16_i = 16'd1;
        bus.sad16x8_i = {16'd1, 16'd1};
        bus.sad8x16_i = {16'd1, 16'd1};
        bus.sad8x8_i = {16'd1, 16'd1, 16'd1, 16'd1};
      end else begin
        bus.sad_v_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_cand_v"}, 64'(bus.cand_v_o), 64'd0);
    chk({tag, "_cand_mv"}, 64'(bus.cand_mv_o), 64'd0);
    chk({tag, "_best_mv"}, 64'(|bus.best_mv_o), 64'd0);
    chk({tag, "_best_sad"}, 64'(|bus.best_sad_o), 64'd0);
  endtask

  task automatic start_search(input int m);
    mode = m;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("start_busy", 64'(bus.busy_o), 64'd1);
    chk("start_cand_v", 64'(bus.cand_v_o), 64'd1);
    chk("start_cand_mv", 64'(bus.cand_mv_o), 64'(mvp(-2, -2)));
  endtask

  task automatic wait_done();
    for (int n = 0; n < 600; n++) begin
      if (bus.done_o) break;
      tick();
    end
    chk("done_seen", 64'(bus.done_o), 64'd1);
    chk("done_latency", 64'(cyc), 64'(last_sad_cyc + 1));
    chk("done_busy_low", 64'(bus.busy_o), 64'd0);
    chk("issued_count", 64'(exp_iss), 64'(NC));
    chk("returned_count", 64'(ret_idx), 64'(NC));
    tick();
    chk("done_one_cycle", 64'(bus.done_o), 64'd0);
    tick();
    chk("done_no_repeat", 64'(bus.done_o), 64'd0);
  endtask

  task automatic check_best(input int m);
    logic [13:0] emv;
    logic [15:0] esad;
    for (int p = 0; p < 9; p++) begin
      case (m)
        1: begin emv = mvp(-2, -2); esad = 16'd100; end
        2: begin
          emv  = (p == 0) ? mvp(0, 1) : mvp(-2, -2);
          esad = (p == 0) ? 16'd50 : 16'd200;
        end
        3: begin emv = idx_mv(plant(p)); esad = 16'(10 + p); end
        default: begin emv = '0; esad = '0; end
      endcase
      chk($sformatf("m%0d_best_mv[%0d]", m, p), 64'(bus.best_mv_o[p*14 +: 14]), 64'(emv));
      chk($sformatf("m%0d_best_sad[%0d]", m, p), 64'(bus.best_sad_o[p*16 +: 16]), 64'(esad));
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.cand_rdy_i = 1'b0;
    bus.sad_v_i = 1'b0;
    bus.sad8x8_i = '0;
    bus.sad8x16_i = '0;
    bus.sad16x8_i = '0;
    bus.sad16x16_i = '0;
    tick();
    tick();
    chk_reset_vals("reset");
    rstn = 1'b1;
    tick();

    // Uniform SADs, fixed latency: ties keep the first candidate.
    start_search(1);
    wait_done();
    check_best(1);

    // Single 16x16 minimum at (0,1).
    start_search(2);
    wait_done();
    check_best(2);

    // Distinct planted minimum per partition checks packing.
    start_search(3);
    wait_done();
    check_best(3);

    // Random backpressure and return latency.
    rand_rdy = 1'b1;
    rand_lat = 1'b1;
    start_search(3);
    wait_done();
    check_best(3);
    start_search(1);
    wait_done();
    check_best(1);
    rand_rdy = 1'b0;
    rand_lat = 1'b0;

    // start_i during RUN, then sad_v_i while IDLE.
    start_search(2);
    repeat (4) tick();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("restart_ignored_busy", 64'(bus.busy_o), 64'd1);
    wait_done();
    check_best(2);
    inject = 1'b1;
    tick();
    tick();
    inject = 1'b0;
    tick();
    check_best(2);
    start_search(3);
    wait_done();
    check_best(3);

    // Reset in the middle of a search.
    start_search(1);
    for (int n = 0; n < 100; n++) begin
      if (exp_iss >= 5) break;
      tick();
    end
    chk("mid_reset_issue_progress", 64'(exp_iss >= 5), 64'd1);
    rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    chk_reset_vals("midrst_hold");
    rstn = 1'b1;
    tick();
    chk_reset_vals("post_rst");
    start_search(3);
    wait_done();
    check_best(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
